// File: rtl/keypad_digit_buffer.sv
// rtl/keypad_digit_buffer.sv - debounced keypad decoder feeding a BCD digit entry buffer
//
// Purpose:
//   Debounces a one-hot keypad code, maps it to a BCD digit, CLEAR or
//   BACKSPACE, and maintains a shift-in digit buffer with a saturating count.
//   Optional macro KEYPAD_AUTOREPEAT_EN adds auto-repeat of held digit and
//   BACKSPACE keys; without it every press yields exactly one action.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_onehot       one-hot key code from the scanner, 0 = no key
//   o_digits       BCD buffer, [3:0] holds the most recent digit
//   o_count        number of valid digits, saturates at DIGITS
//   o_binary       last accepted digit value
//   o_key_valid    one-cycle pulse per accepted digit
//   o_cmd_valid    one-cycle pulse per accepted CLEAR / BACKSPACE
//   o_invalid_key  sticky flag for a debounced unmapped code, cleared by CLEAR

module keypad_digit_buffer #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 4,
   parameter int REPEAT_CYCLES = 1000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [15:0]           i_onehot,
   output logic [4*DIGITS-1:0]   o_digits,
   output logic [CNT_W-1:0]      o_count,
   output logic [3:0]            o_binary,
   output logic                  o_key_valid,
   output logic                  o_cmd_valid,
   output logic                  o_invalid_key
);

   localparam int DW = 4 * DIGITS;
   localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DIGITS);

   generate
      if (DIGITS < 1 || DIGITS > 8 || STABLE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
          (DIGITS >> CNT_W) != 0) begin : g_bad_param
         $error("keypad_digit_buffer: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;
   typedef enum logic [1:0] {K_DIGIT, K_CLEAR, K_BKSP, K_INVALID} kind_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [15:0]     r_cand, w_cand_nxt;
   logic            w_accept;
   logic            w_apply;
   kind_t           w_kind;
   logic [3:0]      w_digit;

   logic [DW-1:0]    r_digits;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_binary;
   logic             r_key_valid;
   logic             r_cmd_valid;
   logic             r_invalid_key;

   // Key map; anything not listed (including multi-bit codes) is invalid.
   always_comb begin
      w_kind  = K_INVALID;
      w_digit = 4'd0;
      case (i_onehot)
         16'h0008: begin w_kind = K_DIGIT; w_digit = 4'd0; end
         16'h0080: begin w_kind = K_DIGIT; w_digit = 4'd1; end
         16'h0040: begin w_kind = K_DIGIT; w_digit = 4'd2; end
         16'h0020: begin w_kind = K_DIGIT; w_digit = 4'd3; end
         16'h0800: begin w_kind = K_DIGIT; w_digit = 4'd4; end
         16'h0400: begin w_kind = K_DIGIT; w_digit = 4'd5; end
         16'h0200: begin w_kind = K_DIGIT; w_digit = 4'd6; end
         16'h8000: begin w_kind = K_DIGIT; w_digit = 4'd7; end
         16'h4000: begin w_kind = K_DIGIT; w_digit = 4'd8; end
         16'h2000: begin w_kind = K_DIGIT; w_digit = 4'd9; end
         16'h1000: w_kind = K_CLEAR;
         16'h0100: w_kind = K_BKSP;
         default:  w_kind = K_INVALID;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
      end
   end

   // r_cnt counts identical samples, including the one that entered the state,
   // so acceptance/release happens on the STABLE_CYCLES-th matching edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_onehot != 16'h0) begin
               w_cand_nxt = i_onehot;
               w_cnt_nxt  = CW'(1);
               if (STABLE_CYCLES == 1) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_HELD;
               end else begin
                  w_state_nxt = S_DEBOUNCE;
               end
            end
         end
         S_DEBOUNCE: begin
            if (i_onehot == 16'h0) begin
               w_state_nxt = S_IDLE;
            end else if (i_onehot == r_cand) begin
               if (32'(r_cnt) + 1 >= STABLE_CYCLES) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_HELD;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end else begin
               w_cand_nxt = i_onehot;
               w_cnt_nxt  = CW'(1);
            end
         end
         S_HELD: begin
            if (i_onehot == 16'h0) begin
               w_cnt_nxt   = CW'(1);
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (i_onehot != 16'h0) begin
               w_state_nxt = S_HELD;
            end else if (32'(r_cnt) + 1 >= STABLE_CYCLES) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW       = $clog2(REPEAT_CYCLES + 1);
   localparam int REP_FAST = (REPEAT_CYCLES / 4 < 1) ? 1 : REPEAT_CYCLES / 4;

   logic [RW-1:0] r_rep_cnt;
   logic          r_rep_fast;
   logic          w_rep_hold;
   logic          w_repeat;

   // Only an unbroken hold of the accepted key in HELD advances the timer.
   assign w_rep_hold = (r_state == S_HELD) && (i_onehot == r_cand) &&
                       (w_kind == K_DIGIT || w_kind == K_BKSP);
   assign w_repeat   = w_rep_hold &&
                       (32'(r_rep_cnt) + 1 >= (r_rep_fast ? REP_FAST : REPEAT_CYCLES));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rep_cnt  <= '0;
         r_rep_fast <= 1'b0;
      end else if (w_repeat) begin
         r_rep_cnt  <= '0;
         r_rep_fast <= 1'b1;
      end else if (w_rep_hold) begin
         r_rep_cnt  <= r_rep_cnt + RW'(1);
      end else begin
         r_rep_cnt  <= '0;
         r_rep_fast <= 1'b0;
      end
   end

   assign w_apply = w_accept | w_repeat;
`else
   assign w_apply = w_accept;
`endif

   // On an applying edge i_onehot equals the candidate, so its decode is used.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_digits      <= '0;
         r_count       <= '0;
         r_binary      <= 4'd0;
         r_key_valid   <= 1'b0;
         r_cmd_valid   <= 1'b0;
         r_invalid_key <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         r_cmd_valid <= 1'b0;
         if (w_apply) begin
            case (w_kind)
               K_DIGIT: begin
                  r_digits    <= (r_digits << 4) | DW'(w_digit);
                  if (r_count != MAX_COUNT) r_count <= r_count + CNT_W'(1);
                  r_binary    <= w_digit;
                  r_key_valid <= 1'b1;
               end
               K_CLEAR: begin
                  r_digits      <= '0;
                  r_count       <= '0;
                  r_invalid_key <= 1'b0;
                  r_cmd_valid   <= 1'b1;
               end
               K_BKSP: begin
                  r_digits    <= r_digits >> 4;
                  if (r_count != '0) r_count <= r_count - CNT_W'(1);
                  r_cmd_valid <= 1'b1;
               end
               default: r_invalid_key <= 1'b1;
            endcase
         end
      end
   end

   assign o_digits      = r_digits;
   assign o_count       = r_count;
   assign o_binary      = r_binary;
   assign o_key_valid   = r_key_valid;
   assign o_cmd_valid   = r_cmd_valid;
   assign o_invalid_key = r_invalid_key;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// tb/tb_keypad_digit_buffer.sv - directed vector bench for keypad_digit_buffer

module tb_keypad_digit_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] onehot;
   logic [15:0] digits;
   logic [3:0]  count;
   logic [3:0]  binary;
   logic        key_valid;
   logic        cmd_valid;
   logic        invalid_key;

   always #5 clk = ~clk;

   keypad_digit_buffer #(
      .DIGITS(4), .STABLE_CYCLES(4), .CNT_W(4), .REPEAT_CYCLES(1000)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_onehot(onehot),
      .o_digits(digits), .o_count(count), .o_binary(binary),
      .o_key_valid(key_valid), .o_cmd_valid(cmd_valid), .o_invalid_key(invalid_key)
   );

   typedef struct {
      logic [15:0] code;
      logic [15:0] dig;
      logic [3:0]  cnt;
      logic [3:0]  bin;
      logic        kv;
      logic        cv;
      logic        inv;
   } vec_t;

   vec_t        tbl[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] e_d = 16'h0;
   logic [3:0]  e_c = 4'd0;
   logic [3:0]  e_b = 4'd0;
   logic        e_i = 1'b0;

   task automatic chk(input string name, input logic [15:0] xd, input logic [3:0] xc,
                      input logic [3:0] xb, input logic xkv, input logic xcv, input logic xinv);
      n_vec++;
      if (digits !== xd || count !== xc || binary !== xb || key_valid !== xkv ||
          cmd_valid !== xcv || invalid_key !== xinv) begin
         n_err++;
         $display("FAIL %s: got digits=%h count=%0d binary=%0d kv=%b cv=%b inv=%b, expected digits=%h count=%0d binary=%0d kv=%b cv=%b inv=%b",
                  name, digits, count, binary, key_valid, cmd_valid, invalid_key,
                  xd, xc, xb, xkv, xcv, xinv);
      end
   endtask

   task automatic step(input logic [15:0] code);
      onehot = code;
      @(posedge clk);
      #1;
   endtask

   task automatic sc(input string name, input logic [15:0] code, input logic [15:0] xd,
                     input logic [3:0] xc, input logic [3:0] xb, input logic xkv,
                     input logic xcv, input logic xinv);
      step(code);
      chk(name, xd, xc, xb, xkv, xcv, xinv);
   endtask

   task automatic add(input logic [15:0] code, input logic [15:0] xd, input logic [3:0] xc,
                      input logic [3:0] xb, input logic xkv, input logic xcv, input logic xinv);
      vec_t v;
      v.code = code; v.dig = xd; v.cnt = xc; v.bin = xb; v.kv = xkv; v.cv = xcv; v.inv = xinv;
      tbl.push_back(v);
   endtask

   // A clean press: 3 edges of unchanged outputs, accept on the 4th, then 4 release edges.
   task automatic add_press(input logic [15:0] code, input logic [15:0] xd, input logic [3:0] xc,
                            input logic [3:0] xb, input logic xkv, input logic xcv, input logic xinv);
      for (int k = 0; k < 3; k++) add(code, e_d, e_c, e_b, 1'b0, 1'b0, e_i);
      add(code, xd, xc, xb, xkv, xcv, xinv);
      e_d = xd; e_c = xc; e_b = xb; e_i = xinv;
      for (int k = 0; k < 4; k++) add(16'h0, e_d, e_c, e_b, 1'b0, 1'b0, e_i);
   endtask

   initial begin
      rst_n  = 1'b0;
      onehot = 16'h0;
      #12;
      chk("reset", 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

      add_press(16'h0080, 16'h0001, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
      add_press(16'h0040, 16'h0012, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0);
      add_press(16'h0020, 16'h0123, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
      add_press(16'h0100, 16'h0012, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0);
      add_press(16'h1000, 16'h0000, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
      add_press(16'h0100, 16'h0000, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
      add_press(16'h0080, 16'h0001, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
      add_press(16'h0040, 16'h0012, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0);
      add_press(16'h0020, 16'h0123, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
      add_press(16'h0800, 16'h1234, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0);
      add_press(16'h0400, 16'h2345, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
      add_press(16'h0003, 16'h2345, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1);
      add_press(16'h0001, 16'h2345, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1);
      add_press(16'h1000, 16'h0000, 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
      add_press(16'h0008, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0);
      add_press(16'h2000, 16'h0009, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0);
      add_press(16'h8000, 16'h0097, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0);
      add_press(16'h4000, 16'h0978, 4'd4, 4'd8, 1'b1, 1'b0, 1'b0);
      add_press(16'h0800, 16'h9784, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0);
      add_press(16'h0400, 16'h7845, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
      add_press(16'h0200, 16'h8456, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].code);
         chk($sformatf("vec%0d", i), tbl[i].dig, tbl[i].cnt, tbl[i].bin,
             tbl[i].kv, tbl[i].cv, tbl[i].inv);
      end

      // Press bounce: the short burst must not leave any debounce progress.
      sc("bounce_a1", 16'h0040, 16'h8456, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0);
      sc("bounce_a2", 16'h0040, 16'h8456, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0);
      sc("bounce_gap", 16'h0000, 16'h8456, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         sc("bounce_b", 16'h0040, 16'h8456, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0);
      sc("bounce_acc", 16'h0040, 16'h4562, 4'd4, 4'd2, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         sc("bounce_rel", 16'h0000, 16'h4562, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0);

      // Release glitch and a different key while held must not re-accept.
      for (int k = 0; k < 3; k++)
         sc("glitch_press", 16'h0020, 16'h4562, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0);
      sc("glitch_acc", 16'h0020, 16'h5623, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0);
      sc("glitch_hold", 16'h0020, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      sc("glitch_zero", 16'h0000, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         sc("glitch_back", 16'h0020, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         sc("held_other", 16'h0080, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         sc("glitch_rel", 16'h0000, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         sc("second_press", 16'h0020, 16'h5623, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      sc("second_acc", 16'h0020, 16'h6233, 4'd4, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         sc("second_rel", 16'h0000, 16'h6233, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a debounce: outputs clear at once, candidate is lost.
      sc("rst_deb1", 16'h0080, 16'h6233, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      sc("rst_deb2", 16'h0080, 16'h6233, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++)
         sc("post_rst", 16'h0080, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      sc("post_rst_acc", 16'h0080, 16'h0001, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
      sc("post_rst_rel", 16'h0000, 16'h0001, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
